// File: rtl/lru_victim_select_pkg.sv
// ============================================================================
// Module      : lru_pkg
// Description : Shared types and widths for the LRU victim selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lru_pkg;

    localparam int AGE_W = 3;

    typedef logic [AGE_W-1:0] age_t;
    typedef logic [2:0]       way_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUPD = 2'd1,
        SCAN = 2'd2,
        VUPD = 2'd3
    } lru_state_t;

endpackage : lru_pkg

`default_nettype wire

// File: rtl/lru_victim_select_agtb.sv
// ============================================================================
// Module      : AGtB
// Description : Strict greater-than comparator for two ages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module AGtB
    import lru_pkg::*;
(
    input  age_t in1,
    input  age_t in2,
    output logic AGtBOut
);

    assign AGtBOut = (in1 > in2);

endmodule : AGtB

`default_nettype wire

// File: rtl/lru_victim_select.sv
// ============================================================================
// Module      : lru_victim_select
// Description : Per-set LRU age tracker; scans a set on a miss for the oldest
//               way. Optional hit/miss counters when LRU_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lru_victim_select
    import lru_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int SETS  = 16,
    parameter int IDX_W = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_valid,
    input  logic [IDX_W-1:0] acc_index,
    input  logic             acc_hit,
    input  logic [2:0]       acc_way,
    output logic             acc_ready,
    output logic             vict_valid,
    output logic [2:0]       vict_way,
    output logic [IDX_W-1:0] vict_index
`ifdef LRU_STATS_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);

    localparam way_t C_LAST_WAY = way_t'(WAYS - 1);

    lru_state_t       r_state;
    age_t             r_age [SETS][WAYS];
    logic [IDX_W-1:0] r_idx;
    way_t             r_way;
    way_t             r_best;
    way_t             r_cur;

    logic             w_gt;
    way_t             w_best_next;

    // New age of one way when way t (age at) becomes MRU.
    function automatic age_t touch(input age_t a, input age_t at, input logic is_t);
        if (is_t)
            return '0;
        else if (a < at)
            return a + age_t'(1);
        else
            return a;
    endfunction

    AGtB u_agtb (
        .in1     (r_age[r_idx][r_cur]),
        .in2     (r_age[r_idx][r_best]),
        .AGtBOut (w_gt)
    );

    assign w_best_next = w_gt ? r_cur : r_best;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            acc_ready  <= 1'b1;
            vict_valid <= 1'b0;
            vict_way   <= '0;
            vict_index <= '0;
            r_idx      <= '0;
            r_way      <= '0;
            r_best     <= '0;
            r_cur      <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= age_t'(w);
        end else begin
            case (r_state)
                IDLE: begin
                    if (acc_valid) begin
                        r_idx     <= acc_index;
                        r_way     <= acc_way;
                        acc_ready <= 1'b0;
                        r_best    <= '0;
                        r_cur     <= way_t'(1);
                        r_state   <= acc_hit ? HUPD : SCAN;
                    end
                end
                HUPD: begin
                    if (int'(r_way) < WAYS)
                        for (int w = 0; w < WAYS; w++)
                            r_age[r_idx][w] <= touch(r_age[r_idx][w],
                                                     r_age[r_idx][r_way],
                                                     way_t'(w) == r_way);
                    acc_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                SCAN: begin
                    r_best <= w_best_next;
                    r_cur  <= r_cur + way_t'(1);
                    // Victim is registered on the last compare so it is valid in VUPD.
                    if (r_cur == C_LAST_WAY) begin
                        vict_valid <= 1'b1;
                        vict_way   <= w_best_next;
                        vict_index <= r_idx;
                        r_state    <= VUPD;
                    end
                end
                VUPD: begin
                    for (int w = 0; w < WAYS; w++)
                        r_age[r_idx][w] <= touch(r_age[r_idx][w],
                                                 r_age[r_idx][r_best],
                                                 way_t'(w) == r_best);
                    vict_valid <= 1'b0;
                    acc_ready  <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LRU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == IDLE && acc_valid) begin
            if (acc_hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            else if (!acc_hit && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif

endmodule : lru_victim_select

`default_nettype wire

// File: doc/lru_victim_select.md
# lru_victim_select

Per-set LRU age tracker and victim selector for the set-associative cache. It holds a 3-bit age for every way of every set and updates those ages on each cache access. On a miss it scans the ways of the addressed set and returns the oldest way as the replacement victim. The scan issues one age-pair comparison per cycle to a single `AGtB` instance. The block sits between the tag-compare stage (upstream: hit/miss, way) and the refill controller (downstream: victim way).

## Interface
Parameters:
- `WAYS`, 8: ways per set, 2..8; ages and way numbers are 3 bits.
- `SETS`, 16: number of sets.
- `IDX_W`, 4: set index width; `SETS` ≤ 2^`IDX_W`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `acc_valid` in 1: access request from tag compare.
- `acc_index` in `IDX_W`: set index of the access.
- `acc_hit` in 1: 1 = hit, 0 = miss.
- `acc_way` in 3: way that hit; ignored on a miss.
- `acc_ready` out 1: block can accept an access.
- `vict_valid` out 1: one-cycle strobe; the victim is valid.
- `vict_way` out 3: selected victim way.
- `vict_index` out `IDX_W`: set index of the victim.

## Operation
- **Age state**
  - `age[s][w]`, 3 bits each.
  - Within a set the ages are always a permutation of 0..`WAYS`-1. 0 = MRU, `WAYS`-1 = LRU.
- **Reset**
  - `age[s][w] = w` for every set.
  - State IDLE; `acc_ready` = 1; `vict_valid` = 0; `vict_way` = 0; `vict_index` = 0.
- **Handshake**
  - An access is accepted on an edge where `acc_valid` && `acc_ready`.
  - `acc_index`, `acc_hit` and `acc_way` are latched at that edge.
  - `acc_ready` is 1 only in IDLE.
- **Touch(s, t)**, the single update rule:
  - Every way `w` with `age[s][w] < age[s][t]` increments.
  - `age[s][t]` becomes 0.
  - All other ways are unchanged.
- **State machine**
  - IDLE: on a hit access go to HUPD. On a miss access go to SCAN with `best` = 0, `cur` = 1.
  - HUPD: perform Touch(idx, way), then go to IDLE. If `acc_way` ≥ `WAYS`, no ages change.
  - SCAN: the `AGtB` comparator gets `in1` = `age[idx][cur]` and `in2` = `age[idx][best]`.
    - If `AGtBOut` = 1, `best` ← `cur`.
    - `cur` increments each cycle. After `cur` = `WAYS`-1 is evaluated, go to VUPD.
    - The compare is strictly greater-than, so on any tie the lower way index wins.
  - VUPD: drive `vict_valid` = 1 with `vict_way` = `best` and `vict_index` = idx. Perform Touch(idx, best), then go to IDLE.
- **Register behaviour**
  - `vict_way` and `vict_index` hold their last values when `vict_valid` = 0.
  - Ages of sets other than idx never change during an operation.
- **Reset mid-operation**
  - `rst` has priority in every state.
  - An in-flight scan is abandoned with no `vict_valid` pulse.
  - All ages re-initialise.

## Timing
- Accept edge = edge 0.
- **Hit**
  - HUPD occupies cycle 1; the ages are updated at edge 1.
  - `acc_ready` returns to 1 in cycle 2.
  - Throughput: one hit every 2 cycles.
- **Miss**
  - SCAN occupies cycles 1..`WAYS`-1; VUPD occupies cycle `WAYS`.
  - `vict_valid` is high during cycle `WAYS` only (cycle 8 for 8 ways).
  - Ages are updated at the end of that cycle; `acc_ready` is 1 in cycle `WAYS`+1.
- **Output and input paths**
  - All outputs come directly from registers, with no combinational path from inputs.
  - `acc_valid` held high while `acc_ready` = 0 is not accepted and is not lost; it is accepted on the first IDLE edge.

## Configuration
- `LRU_STATS_EN`
  - Defined: adds outputs `hit_cnt` and `miss_cnt`, 16 bits each.
  - They increment on each accepted hit or miss respectively and saturate at 0xFFFF.
  - Both clear on `rst`.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- **Package `lru_pkg`**
  - `AGE_W` = 3.
  - `age_t` (3-bit age).
  - `way_t` (3-bit way).
  - State enum `lru_state_t` {IDLE, HUPD, SCAN, VUPD}.
- **Sub-module**
  - Exactly one `AGtB` instance for the scan compare.
  - The Touch logic is an in-module function.

## Test plan
- **Reset initialisation:** after `rst`, issue a miss on set 3 → `vict_valid` in cycle 8, `vict_way` = 7, `vict_index` = 3. Afterwards set 3 ages are way7 = 0, ways 0..6 = 1..7.
- **Hit update:** from reset, hit set 0 way 2 → set 0 ages become {1,2,0,3,4,5,6,7}. A following miss on set 0 → `vict_way` = 7.
- **Ordering:** hit ways 7,6,5,4,3,2,1 on set 5, then miss → `vict_way` = 0. A second miss → `vict_way` = 7.
- **Back-pressure:** hold `acc_valid` high with alternating hit/miss → each accepted only while `acc_ready` = 1. Exactly one `vict_valid` pulse per miss and no dropped access.
- **Reset mid-scan:** assert `rst` in cycle 4 of a miss → no `vict_valid`, ages back to w. The next miss returns `vict_way` = 7.
- **Statistics (`LRU_STATS_EN` defined):** 3 hits and 2 misses → `hit_cnt` = 3, `miss_cnt` = 2. Preloading `hit_cnt` to 0xFFFF saturates it.
